// File: rtl/jk_seq_ctrl_pkg.sv
// jk_seq_ctrl_pkg: opcodes, FSM state encoding and opcode helpers for the JK sequencer.
package jk_seq_ctrl_pkg;
    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_CLEAR    = 3'b001;
    localparam logic [2:0] OP_SET      = 3'b010;
    localparam logic [2:0] OP_LOAD     = 3'b011;
    localparam logic [2:0] OP_TOGGLE   = 3'b100;
    localparam logic [2:0] OP_COUNT_UP = 3'b101;
    localparam logic [2:0] OP_COUNT_DN = 3'b110;
    localparam logic [2:0] OP_RSVD     = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    function automatic logic is_count(input logic [2:0] op);
        return op == OP_COUNT_UP || op == OP_COUNT_DN;
    endfunction
endpackage

// File: rtl/jk_seq_ctrl_cell.sv
// jk_ff_cell: single JK flip-flop (00 hold, 01 reset, 10 set, 11 toggle), async active-low reset to 0.
module jk_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else        q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command-driven sequencer driving the J/K inputs of a WIDTH-cell JK register bank.
module jk_seq_ctrl
    import jk_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    state_t           state, nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r, j, k, up_c, dn_c;
    logic [CNT_W-1:0] rem;
    logic             accept;

    assign cmd_ready = state == S_IDLE;
    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (accept) nxt = (is_count(cmd_op) && cmd_len == '0) ? S_DONE : S_EXEC;
            S_EXEC:  if (!is_count(op_r) || rem == CNT_W'(1)) nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_r   <= OP_NOP;
            data_r <= '0;
            rem    <= '0;
        end else if (accept) begin
            op_r   <= cmd_op;
            data_r <= cmd_data;
            rem    <= cmd_len;
        end else if (state == S_EXEC) begin
            rem    <= rem - 1'b1;
        end

    // Ripple enables: cell i toggles when all lower cells are 1 (up) or 0 (down).
    always_comb begin
        up_c    = '0;
        dn_c    = '0;
        up_c[0] = 1'b1;
        dn_c[0] = 1'b1;
        for (int b = 1; b < WIDTH; b++) begin
            up_c[b] = up_c[b-1] & q[b-1];
            dn_c[b] = dn_c[b-1] & ~q[b-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (state == S_EXEC)
            case (op_r)
                OP_CLEAR:    k = '1;
                OP_SET:      j = '1;
                OP_LOAD:     begin j = data_r; k = ~data_r; end
                OP_TOGGLE:   begin j = data_r; k = data_r;  end
                OP_COUNT_UP: begin j = up_c;   k = up_c;    end
                OP_COUNT_DN: begin j = dn_c;   k = dn_c;    end
                default:     ;
            endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (.clk(clk), .rst_n(rst_n), .j(j[i]), .k(k[i]), .q(q[i]));
    end
endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: directed vectors with hand-computed expectations for jk_seq_ctrl (WIDTH=4, CNT_W=8).
module tb_jk_seq_ctrl;
    import jk_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic [3:0] q;
    logic       busy;
    logic       done;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_done;

    jk_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .q(q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for ready, return 1 time unit after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [7:0] len,
                         input bit hold = 0);
        int waited = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        step();
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Single-step command: q final one edge after accept, done for exactly one cycle.
    task automatic single(input string tag, input logic [2:0] op, input logic [3:0] data,
                          input logic [3:0] exp_q);
        issue(op, data, 8'd0);
        check({tag, "_busy"}, busy, 1);
        step();
        check({tag, "_q"}, q, exp_q);
        check({tag, "_done"}, done, 1);
        step();
        check({tag, "_done_low"}, done, 0);
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    initial begin
        logic [3:0] up_seq [5];
        logic [3:0] dn_seq [3];
        up_seq = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
        dn_seq = '{4'b0000, 4'b1111, 4'b1110};
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; cmd_len = '0;
        #3;
        check("rst_q", q, 4'b0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        single("load", OP_LOAD, 4'b1010, 4'b1010);
        single("set", OP_SET, 4'b0000, 4'b1111);
        single("clear", OP_CLEAR, 4'b1111, 4'b0000);
        single("load2", OP_LOAD, 4'b1010, 4'b1010);

        issue(OP_TOGGLE, 4'b0110, 8'd0, 1);
        step();
        check("tog_q", q, 4'b1100);
        check("tog_done", done, 1);
        step();
        cmd_valid = 1'b0;
        check("tog_idle", busy, 0);
        check("tog_q_hold", q, 4'b1100);
        step();
        check("tog_no_second", busy, 0);
        check("tog_q_final", q, 4'b1100);

        single("rsvd", OP_RSVD, 4'b1111, 4'b1100);
        single("nop", OP_NOP, 4'b1111, 4'b1100);

        single("load_up", OP_LOAD, 4'b1101, 4'b1101);
        issue(OP_COUNT_UP, 4'b0000, 8'd5);
        n_done = 0;
        for (int s = 0; s < 5; s++) begin
            step();
            check($sformatf("up_q%0d", s), q, up_seq[s]);
            n_done += int'(done);
        end
        check("up_done_last", done, 1);
        step();
        n_done += int'(done);
        check("up_done_count", n_done, 1);

        single("load_dn", OP_LOAD, 4'b0001, 4'b0001);
        issue(OP_COUNT_DN, 4'b0000, 8'd3);
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("dn_q%0d", s), q, dn_seq[s]);
        end
        check("dn_done", done, 1);
        step();
        check("dn_done_low", done, 0);

        issue(OP_COUNT_UP, 4'b0000, 8'd0);
        check("len0_done", done, 1);
        check("len0_q", q, 4'b1110);
        step();
        check("len0_idle", busy, 0);
        check("len0_q_hold", q, 4'b1110);

        single("clr6", OP_CLEAR, 4'b0000, 4'b0000);
        issue(OP_COUNT_UP, 4'b0000, 8'd10);
        for (int s = 0; s < 3; s++) step();
        check("abort_pre_q", q, 4'b0011);
        rst_n = 1'b0;
        #1;
        check("abort_q", q, 4'b0000);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        n_done = 0;
        for (int s = 0; s < 3; s++) begin
            step();
            n_done += int'(done);
        end
        check("abort_no_done", n_done, 0);
        rst_n = 1'b1;
        step();
        check("abort_ready", cmd_ready, 1);
        single("post_load", OP_LOAD, 4'b0101, 4'b0101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
